bw_clk_gclk_div: RTL and testbench
==================================

Name: bw_clk_gclk_div

Overview:
Programmable integer clock divider that generates the divided global clock driving the gclk inverter/buffer tree. It also produces a one-cycle sync pulse aligned to each divided rising edge. Ratio changes are glitch-free and take effect only at period boundaries. A stop/ack handshake parks the divided clock low for clock-stop sequences.

Parameters:
DIV_W, 4, width of ratio fields; legal ratios 2..2^DIV_W-1
RST_RATIO, 2, active divide ratio loaded at reset

Ports:
clk  input  1  source clock
rst  input  1  reset, asynchronous, active-high
div_ratio  input  DIV_W  requested divide ratio R; values 0 and 1 clamp to 2
ratio_ld  input  1  single-cycle strobe; captures div_ratio as the pending ratio
stop_req  input  1  level; request to park the divided clock low
gclk_out  output  1  divided clock, registered; feeds the gclk inverter stage
sync_pulse  output  1  high for the one clk cycle in which gclk_out rises
stop_ack  output  1  high while the divider is parked
ratio_busy  output  1  high while a pending ratio awaits a period boundary

Behaviour:
- Single clock domain. Reset is asynchronous and active-high.
- Reset values:
  - state=RUN, act_ratio=RST_RATIO, cnt=RST_RATIO-1.
  - gclk_out=0, sync_pulse=0, stop_ack=0, ratio_busy=0.
- HI = ceil(R/2) and LO = floor(R/2), both computed from act_ratio. cnt runs 0..R-1.
- RUN state, every cycle:
  - cnt_nxt = (cnt==R-1) ? 0 : cnt+1.
  - gclk_out <= (cnt_nxt < HI).
  - sync_pulse <= (cnt_nxt==0).
- First edge after reset release: cnt=0, gclk_out=1, sync_pulse=1. Latency from reset release is exactly 1 clk.
- Ratio load:
  - ratio_ld captures clamped div_ratio into pend_ratio and sets ratio_busy the following cycle.
  - At a wrap (cnt==R-1 in RUN), or on restart from STOPPED: act_ratio <= pend_ratio and ratio_busy <= 0.
  - ratio_ld in the wrap cycle itself applies the new value at that wrap; ratio_busy stays 0.
  - A repeated ratio_ld while busy overwrites pend_ratio; last value wins.
  - act_ratio never changes mid-period, so there are no runt high or low phases.
- Stop:
  - In RUN with stop_req=1 at cnt==R-1, go to STOPPED.
  - On entry: cnt holds R-1, gclk_out <= 0, sync_pulse <= 0, stop_ack <= 1.
  - stop_req asserted mid-period finishes the current period first. The low phase is always complete before parking.
- STOPPED:
  - Outputs are held and ratio_ld is still accepted.
  - When stop_req=0, go to RUN next edge: cnt=0, gclk_out=1, sync_pulse=1, stop_ack=0. Any pending ratio is applied at that edge.
- Simultaneous events:
  - stop_req and a wrap in the same cycle: stop wins, and the pending ratio is applied at the later restart, not at the stop.
  - stop_req deasserted then reasserted before the restart edge: only the sampled value matters.
- Reset mid-operation: all state returns to reset values immediately. The pending ratio is discarded.
- Width rules:
  - Compare and increment at DIV_W bits.
  - Clamping happens at capture, so act_ratio is never below 2.

Decomposition:
- Package bw_clk_pkg:
  - state enum {RUN, STOPPED}
  - localparam MIN_RATIO=2
  - function clamp_ratio(): maps 0 and 1 to 2
  - function hi_cnt(): returns ceil(R/2)
- One sub-module is natural: bw_clk_gclk_div_cnt, holding the modulo-R counter plus HI compare and wrap flag. Ratio-pending and stop FSM logic stay in the top.

Test Plan:
- Reset release, RST_RATIO=2 -> gclk_out toggles 1,0,1,0 every clk; sync_pulse high on cycles 1,3,5.
- ratio_ld with div_ratio=5 mid-period at R=2 -> ratio_busy=1 until wrap; then gclk_out high 3 cycles, low 2 cycles, period 5; sync_pulse every 5th cycle.
- div_ratio=0 load -> behaves as R=2; div_ratio=15 -> high 8 cycles, low 7 cycles.
- R=4, stop_req raised at cnt=1 -> two more cycles, then gclk_out=0 and stop_ack=1 at the cnt==3 boundary; stop_req dropped -> next edge gclk_out=1, sync_pulse=1, stop_ack=0.
- ratio_ld(3) while STOPPED, then release -> first restarted period is high 2, low 1; ratio_busy clears at restart.
- rst asserted asynchronously mid high phase at R=6 -> gclk_out=0 and stop_ack=0 immediately; after release, restarts at RST_RATIO with sync_pulse on first edge.

Source files
------------

// File: rtl/bw_clk_gclk_div_pkg.sv
// Shared types and ratio helpers for the gclk divider.
// Helpers take and return 32-bit values; callers cast to DIV_W.
package bw_clk_pkg;

   typedef enum logic {
      RUN     = 1'b0,
      STOPPED = 1'b1
   } state_t;

   localparam int unsigned MIN_RATIO = 2;

   // Ratios 0 and 1 cannot form a two-phase clock, so they map to MIN_RATIO.
   function automatic int unsigned clamp_ratio(input int unsigned r);
      return (r < MIN_RATIO) ? MIN_RATIO : r;
   endfunction

   // High-phase length: ceil(R/2). Odd ratios get the extra cycle high.
   function automatic int unsigned hi_cnt(input int unsigned r);
      return (r + 1) / 2;
   endfunction

endpackage

// File: rtl/bw_clk_gclk_div_if.sv
// Control/status bundle between the gclk divider and its controller.
interface bw_clk_gclk_div_if #(
   parameter int DIV_W = 4
);
   logic [DIV_W-1:0] div_ratio;
   logic             ratio_ld;
   logic             stop_req;
   logic             gclk_out;
   logic             sync_pulse;
   logic             stop_ack;
   logic             ratio_busy;

   modport master (
      output div_ratio, ratio_ld, stop_req,
      input  gclk_out, sync_pulse, stop_ack, ratio_busy
   );

   modport slave (
      input  div_ratio, ratio_ld, stop_req,
      output gclk_out, sync_pulse, stop_ack, ratio_busy
   );
endinterface

// File: rtl/bw_clk_gclk_div_cnt.sv
// Modulo-R phase counter with wrap flag and next-cycle gclk/sync decode.
module bw_clk_gclk_div_cnt
   import bw_clk_pkg::*;
#(
   parameter int DIV_W     = 4,
   parameter int RST_RATIO = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DIV_W-1:0] ratio,
   input  logic             advance,
   output logic             wrap,
   output logic             gclk_nxt,
   output logic             sync_nxt
);

   logic [DIV_W-1:0] cnt_reg;
   logic [DIV_W-1:0] cnt_next;
   logic [DIV_W-1:0] last_cnt;
   logic [DIV_W-1:0] hi;

   assign last_cnt = ratio - DIV_W'(1);
   assign hi       = DIV_W'(hi_cnt(32'(ratio)));
   assign wrap     = (cnt_reg == last_cnt);
   assign cnt_next = wrap ? '0 : cnt_reg + DIV_W'(1);

   // Decode is on the upcoming count so the registered gclk lines up with it.
   assign gclk_nxt = (cnt_next < hi);
   assign sync_nxt = (cnt_next == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg <= DIV_W'(RST_RATIO - 1);
      end else if (advance) begin
         cnt_reg <= cnt_next;
      end
   end

endmodule

// File: rtl/bw_clk_gclk_div.sv
// Programmable gclk divider: ratio staging applied at period boundaries,
// plus a stop/ack handshake that parks the divided clock low.
module bw_clk_gclk_div
   import bw_clk_pkg::*;
#(
   parameter int DIV_W     = 4,
   parameter int RST_RATIO = 2
) (
   input  logic               clk,
   input  logic               rst,
   bw_clk_gclk_div_if.slave   bus
);

   state_t           state_reg, state_next;
   logic [DIV_W-1:0] act_ratio_reg;
   logic [DIV_W-1:0] pend_ratio_reg;
   logic [DIV_W-1:0] load_val;
   logic             busy_reg;
   logic             gclk_reg, gclk_next;
   logic             sync_reg, sync_next;
   logic             ack_reg, ack_next;
   logic             wrap, gclk_nxt, sync_nxt;
   logic             stopping, restart, boundary, advance;

   assign load_val = DIV_W'(clamp_ratio(32'(bus.div_ratio)));

   assign stopping = (state_reg == RUN) && wrap && bus.stop_req;
   assign restart  = (state_reg == STOPPED) && !bus.stop_req;
   assign boundary = ((state_reg == RUN) && wrap && !bus.stop_req) || restart;
   // Counter freezes at R-1 while parked; resuming from R-1 wraps it to 0.
   assign advance  = (state_reg == RUN) ? !(wrap && bus.stop_req) : !bus.stop_req;

   bw_clk_gclk_div_cnt #(
      .DIV_W     (DIV_W),
      .RST_RATIO (RST_RATIO)
   ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .ratio    (act_ratio_reg),
      .advance  (advance),
      .wrap     (wrap),
      .gclk_nxt (gclk_nxt),
      .sync_nxt (sync_nxt)
   );

   // A load coinciding with a boundary bypasses the pending stage entirely.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         act_ratio_reg  <= DIV_W'(RST_RATIO);
         pend_ratio_reg <= DIV_W'(RST_RATIO);
         busy_reg       <= 1'b0;
      end else if (boundary) begin
         if (bus.ratio_ld) begin
            act_ratio_reg <= load_val;
         end else if (busy_reg) begin
            act_ratio_reg <= pend_ratio_reg;
         end
         busy_reg <= 1'b0;
      end else if (bus.ratio_ld) begin
         pend_ratio_reg <= load_val;
         busy_reg       <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= RUN;
         gclk_reg  <= 1'b0;
         sync_reg  <= 1'b0;
         ack_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         gclk_reg  <= gclk_next;
         sync_reg  <= sync_next;
         ack_reg   <= ack_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         RUN:     if (stopping) state_next = STOPPED;
         STOPPED: if (restart)  state_next = RUN;
         default: state_next = RUN;
      endcase
   end

   always_comb begin
      gclk_next = gclk_reg;
      sync_next = 1'b0;
      ack_next  = ack_reg;
      case (state_reg)
         RUN: begin
            if (stopping) begin
               gclk_next = 1'b0;
               ack_next  = 1'b1;
            end else begin
               gclk_next = gclk_nxt;
               sync_next = sync_nxt;
               ack_next  = 1'b0;
            end
         end
         STOPPED: begin
            if (restart) begin
               gclk_next = 1'b1;
               sync_next = 1'b1;
               ack_next  = 1'b0;
            end
         end
         default: begin
            gclk_next = 1'b0;
            ack_next  = 1'b0;
         end
      endcase
   end

   assign bus.gclk_out   = gclk_reg;
   assign bus.sync_pulse = sync_reg;
   assign bus.stop_ack   = ack_reg;
   assign bus.ratio_busy = busy_reg;

endmodule

// File: tb/tb_bw_clk_gclk_div.sv
// Directed bench for bw_clk_gclk_div: ratio loads, clamping, stop/restart, async reset.
module tb_bw_clk_gclk_div;

   localparam int DIV_W = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   bw_clk_gclk_div_if #(.DIV_W(DIV_W)) bus ();

   bw_clk_gclk_div #(
      .DIV_W     (DIV_W),
      .RST_RATIO (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Walks one full divided period from cnt=0; drops ratio_ld after the first edge.
   task automatic check_period(input string tag, input int hi, input int lo);
      for (int i = 0; i < hi + lo; i++) begin
         tick();
         bus.ratio_ld = 1'b0;
         check_val($sformatf("%s gclk[%0d]", tag, i), 32'(bus.gclk_out), 32'(i < hi));
         check_val($sformatf("%s sync[%0d]", tag, i), 32'(bus.sync_pulse), 32'(i == 0));
      end
      $display("period %s hi=%0d lo=%0d checked", tag, hi, lo);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.div_ratio = '0;
      bus.ratio_ld  = 1'b0;
      bus.stop_req  = 1'b0;
      repeat (3) tick();
      check_val("rst gclk", 32'(bus.gclk_out), 0);
      check_val("rst sync", 32'(bus.sync_pulse), 0);
      check_val("rst ack",  32'(bus.stop_ack), 0);
      check_val("rst busy", 32'(bus.ratio_busy), 0);
      rst = 1'b0;

      // R=2 from reset: 1,0,1,0,... with sync on every high edge
      check_period("r2a", 1, 1);
      check_period("r2b", 1, 1);
      check_period("r2c", 1, 1);

      // Mid-period load of 5 stays pending until the wrap
      tick();
      check_val("mid gclk", 32'(bus.gclk_out), 1);
      bus.div_ratio = 4'd5;
      bus.ratio_ld  = 1'b1;
      tick();
      bus.ratio_ld  = 1'b0;
      check_val("ld5 busy", 32'(bus.ratio_busy), 1);
      check_val("ld5 gclk", 32'(bus.gclk_out), 0);
      check_period("r5a", 3, 2);
      check_val("r5 busy", 32'(bus.ratio_busy), 0);
      check_period("r5b", 3, 2);

      // Load 0 in the wrap cycle: clamps to 2, applied at once, never busy
      bus.div_ratio = 4'd0;
      bus.ratio_ld  = 1'b1;
      check_period("r0a", 1, 1);
      check_val("ld0 busy", 32'(bus.ratio_busy), 0);
      check_period("r0b", 1, 1);

      // Maximum ratio 15
      bus.div_ratio = 4'd15;
      bus.ratio_ld  = 1'b1;
      check_period("r15a", 8, 7);
      check_period("r15b", 8, 7);

      // R=4, stop raised at cnt=1
      bus.div_ratio = 4'd4;
      bus.ratio_ld  = 1'b1;
      check_period("r4", 2, 2);
      tick();
      tick();
      bus.stop_req = 1'b1;
      tick();
      check_val("stop c2 ack",  32'(bus.stop_ack), 0);
      check_val("stop c2 gclk", 32'(bus.gclk_out), 0);
      tick();
      check_val("stop c3 ack",  32'(bus.stop_ack), 0);
      tick();
      check_val("park ack",  32'(bus.stop_ack), 1);
      check_val("park gclk", 32'(bus.gclk_out), 0);
      check_val("park sync", 32'(bus.sync_pulse), 0);

      // Loads while parked: last one (3) wins
      bus.div_ratio = 4'd7;
      bus.ratio_ld  = 1'b1;
      tick();
      check_val("park ld7 busy", 32'(bus.ratio_busy), 1);
      check_val("park ld7 ack",  32'(bus.stop_ack), 1);
      bus.div_ratio = 4'd3;
      tick();
      bus.ratio_ld  = 1'b0;
      check_val("park ld3 gclk", 32'(bus.gclk_out), 0);
      bus.stop_req = 1'b0;
      tick();
      check_val("restart gclk", 32'(bus.gclk_out), 1);
      check_val("restart sync", 32'(bus.sync_pulse), 1);
      check_val("restart ack",  32'(bus.stop_ack), 0);
      check_val("restart busy", 32'(bus.ratio_busy), 0);
      tick();
      check_val("r3 c1 gclk", 32'(bus.gclk_out), 1);
      tick();
      check_val("r3 c2 gclk", 32'(bus.gclk_out), 0);
      check_period("r3", 2, 1);

      // Stop and load in the same wrap cycle: ratio waits for the restart
      bus.stop_req  = 1'b1;
      bus.div_ratio = 4'd6;
      bus.ratio_ld  = 1'b1;
      tick();
      bus.ratio_ld  = 1'b0;
      check_val("stopld ack",  32'(bus.stop_ack), 1);
      check_val("stopld busy", 32'(bus.ratio_busy), 1);
      check_val("stopld gclk", 32'(bus.gclk_out), 0);
      bus.stop_req = 1'b0;
      check_period("r6", 3, 3);
      check_val("r6 busy", 32'(bus.ratio_busy), 0);

      // Async reset mid high phase with a pending ratio that must be discarded
      tick();
      bus.div_ratio = 4'd5;
      bus.ratio_ld  = 1'b1;
      tick();
      bus.ratio_ld  = 1'b0;
      check_val("pre-rst gclk", 32'(bus.gclk_out), 1);
      check_val("pre-rst busy", 32'(bus.ratio_busy), 1);
      #2;
      rst = 1'b1;
      #1;
      check_val("async gclk", 32'(bus.gclk_out), 0);
      check_val("async ack",  32'(bus.stop_ack), 0);
      check_val("async busy", 32'(bus.ratio_busy), 0);
      check_val("async sync", 32'(bus.sync_pulse), 0);
      tick();
      rst = 1'b0;
      check_period("post-rst a", 1, 1);
      check_period("post-rst b", 1, 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
